// File: rtl/eth_sw_pkg.sv
// Shared definitions for the 2x2 Ethernet switch: packet field layout, port addresses,
// arbiter state encoding and a saturating counter helper.
package eth_sw_pkg;

    localparam int unsigned PKT_WIDTH = 130;
    localparam int unsigned SOP_BIT   = 0;
    localparam int unsigned DEST_LSB  = 1;
    localparam int unsigned DEST_MSB  = 32;
    localparam int unsigned EOP_BIT   = PKT_WIDTH - 1;

    localparam logic [31:0] PORT_A_ADDR = 32'h0000_00A0;
    localparam logic [31:0] PORT_B_ADDR = 32'h0000_00B0;

    typedef logic [PKT_WIDTH-1:0] pkt_t;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_SEND = 2'd1;
    localparam arb_state_t ST_DROP = 2'd2;
    localparam arb_state_t ST_GAP  = 2'd3;

    function automatic logic [31:0] pkt_dest(input pkt_t p);
        return p[DEST_MSB:DEST_LSB];
    endfunction

    function automatic logic pkt_ok(input pkt_t p);
        return p[SOP_BIT] & p[EOP_BIT];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer only moves when the owner reports a
// completed transfer, so a lone requester never disturbs the fairness order.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       done_grant,
    output logic       grant,
    output logic       rr_ptr
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= 1'b0;
        end else if (update) begin
            rr_ptr <= ~done_grant;
        end
    end

    always_comb begin
        grant = (req == 2'b11) ? rr_ptr : req[1];
    end

endmodule

// File: rtl/eth_out_port_arb.sv
// Egress-port scheduler: claims matching heads from two show-ahead ingress FIFOs, sends or drops
// them. Optional statistics counters are built when ETH_ARB_STATS_EN is defined.
module eth_out_port_arb
    import eth_sw_pkg::*;
#(
    parameter logic [31:0] MY_PORT_ADDR = PORT_A_ADDR,
    parameter int unsigned IPG_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in0_empty,
    input  logic [PKT_WIDTH-1:0] in0_head,
    output logic                 in0_pop,
    input  logic                 in1_empty,
    input  logic [PKT_WIDTH-1:0] in1_head,
    output logic                 in1_pop,
    output logic                 tx_valid,
    output logic [PKT_WIDTH-1:0] tx_data,
    input  logic                 tx_ready,
    output logic                 tx_src,
    output logic [15:0]          fwd_cnt0,
    output logic [15:0]          fwd_cnt1,
    output logic [15:0]          drop_cnt
);

    localparam int unsigned    GAP_W    = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (IPG_CYCLES > 0) ? GAP_W'(IPG_CYCLES - 1) : '0;

    arb_state_t       state, state_d;
    logic [1:0]       req;
    logic             grant;
    logic             rr_ptr;
    logic             sel_q;
    logic [GAP_W-1:0] gap_cnt;
    pkt_t             head_sel;
    logic             done_send, done_drop, complete;

    always_comb begin
        req[0]   = !in0_empty && (pkt_dest(in0_head) == MY_PORT_ADDR);
        req[1]   = !in1_empty && (pkt_dest(in1_head) == MY_PORT_ADDR);
        head_sel = grant ? in1_head : in0_head;
    end

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .update     (complete),
        .done_grant (sel_q),
        .grant      (grant),
        .rr_ptr     (rr_ptr)
    );

    assign done_send = (state == ST_SEND) && tx_ready;
    assign done_drop = (state == ST_DROP);
    assign complete  = done_send || done_drop;
    assign tx_valid  = (state == ST_SEND);
    // The head stays at the FIFO output until the transfer completes, so a reset re-offers it.
    assign in0_pop   = complete && !sel_q;
    assign in1_pop   = complete && sel_q;

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (|req) state_d = pkt_ok(head_sel) ? ST_SEND : ST_DROP;
            ST_SEND: if (tx_ready) state_d = (IPG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_DROP: state_d = ST_IDLE;
            ST_GAP:  if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            sel_q   <= 1'b0;
            tx_data <= '0;
            tx_src  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && |req) begin
                sel_q <= grant;
                if (pkt_ok(head_sel)) begin
                    tx_data <= head_sel;
                    tx_src  <= grant;
                end
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

`ifdef ETH_ARB_STATS_EN
    logic [15:0] fwd0_q, fwd1_q, drop_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fwd0_q <= '0;
            fwd1_q <= '0;
            drop_q <= '0;
        end else begin
            if (done_send && !sel_q) fwd0_q <= sat_inc16(fwd0_q);
            if (done_send && sel_q)  fwd1_q <= sat_inc16(fwd1_q);
            if (done_drop)           drop_q <= sat_inc16(drop_q);
        end
    end

    assign fwd_cnt0 = fwd0_q;
    assign fwd_cnt1 = fwd1_q;
    assign drop_cnt = drop_q;
`else
    assign fwd_cnt0 = '0;
    assign fwd_cnt1 = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_out_port_arb.sv
// Scoreboard bench for eth_out_port_arb: queue-based FIFO and arbitration model, randomized
// traffic and sink back-pressure, plus directed latency, stall, drop and mid-packet reset cases.
module tb_eth_out_port_arb;
    import eth_sw_pkg::*;

    localparam int unsigned PW  = PKT_WIDTH;
    localparam int unsigned IPG = 2;
    localparam logic [31:0] MY  = PORT_A_ADDR;

    typedef struct packed {
        logic    drop;
        logic    src;
        pkt_t    data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in0_empty = 1'b1, in1_empty = 1'b1;
    logic [PW-1:0] in0_head = '0, in1_head = '0;
    logic          in0_pop, in1_pop;
    logic          tx_valid, tx_src;
    logic [PW-1:0] tx_data;
    logic          tx_ready = 1'b0;
    logic [15:0]   fwd_cnt0, fwd_cnt1, drop_cnt;

    pkt_t f0[$];
    pkt_t f1[$];
    exp_t exp_q[$];
    int   ready_mode = 0;
    int   checks = 0;
    int   errors = 0;
    int   m_fwd0, m_fwd1, m_drop, m_left0, m_left1;

    always #5 clk = ~clk;

    eth_out_port_arb #(
        .MY_PORT_ADDR (MY),
        .IPG_CYCLES   (IPG)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in0_empty (in0_empty),
        .in0_head  (in0_head),
        .in0_pop   (in0_pop),
        .in1_empty (in1_empty),
        .in1_head  (in1_head),
        .in1_pop   (in1_pop),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_src    (tx_src),
        .fwd_cnt0  (fwd_cnt0),
        .fwd_cnt1  (fwd_cnt1),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [31:0] dest, input bit sop, input bit eop);
        logic [159:0] r;
        pkt_t p;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        p = r[PW-1:0];
        p[32:1] = dest;
        p[0] = sop;
        p[PW-1] = eop;
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        int k;
        logic [31:0] d;
        k = $urandom_range(0, 99);
        d = (k < 80) ? MY : ((k < 90) ? PORT_B_ADDR : $urandom());
        return mk(d, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0);
    endfunction

    // Serve the preloaded queues: matching well-formed heads are sent, matching malformed heads
    // are discarded, contention alternates starting with FIFO 0, foreign heads block their FIFO.
    task automatic compute_model();
        pkt_t q0[$];
        pkt_t q1[$];
        pkt_t p;
        bit   r0, r1, g, ptr;
        q0 = f0;
        q1 = f1;
        ptr = 1'b0;
        m_fwd0 = 0; m_fwd1 = 0; m_drop = 0;
        exp_q.delete();
        for (int n = 0; n < 64; n++) begin
            r0 = (q0.size() > 0) && (q0[0][32:1] == MY);
            r1 = (q1.size() > 0) && (q1[0][32:1] == MY);
            if (!r0 && !r1) break;
            g = (r0 && r1) ? ptr : r1;
            p = g ? q1.pop_front() : q0.pop_front();
            if (p[0] && p[PW-1]) begin
                exp_q.push_back('{drop: 1'b0, src: g, data: p});
                if (g) m_fwd1++; else m_fwd0++;
            end else begin
                exp_q.push_back('{drop: 1'b1, src: g, data: p});
                m_drop++;
            end
            ptr = !g;
        end
        m_left0 = q0.size();
        m_left1 = q1.size();
    endtask

    task automatic tick(input bit r);
        pkt_t tmp;
        @(negedge clk);
        rstn = r;
        in0_empty = (f0.size() == 0);
        if (f0.size() != 0) in0_head = f0[0]; else in0_head = '0;
        in1_empty = (f1.size() == 0);
        if (f1.size() != 0) in1_head = f1[0]; else in1_head = '0;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
        #4;
        if (rstn) begin
            if (in0_pop && f0.size() != 0) tmp = f0.pop_front();
            if (in1_pop && f1.size() != 0) tmp = f1.pop_front();
        end
    endtask

    task automatic start_phase();
        @(negedge clk);
        rstn = 1'b0;
        compute_model();
        tick(1'b0);
        tick(1'b0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_src", tx_src, 0);
        chk("rst_pops", {in1_pop, in0_pop}, 0);
        chk("rst_counters", {fwd_cnt0, fwd_cnt1, drop_cnt}, 0);
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1'b1);
        chk({tag, "_drain_left"}, exp_q.size(), 0);
        for (int i = 0; i < IPG + 3; i++) tick(1'b1);
        chk({tag, "_fifo0_left"}, f0.size(), m_left0);
        chk({tag, "_fifo1_left"}, f1.size(), m_left1);
`ifdef ETH_ARB_STATS_EN
        chk({tag, "_fwd_cnt0"}, fwd_cnt0, m_fwd0);
        chk({tag, "_fwd_cnt1"}, fwd_cnt1, m_fwd1);
        chk({tag, "_drop_cnt"}, drop_cnt, m_drop);
`else
        chk({tag, "_fwd_cnt0"}, fwd_cnt0, 0);
        chk({tag, "_fwd_cnt1"}, fwd_cnt1, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
    endtask

    task automatic run_monitor();
        exp_t          e;
        bit            prev_stall = 0, prev_valid = 0, seen_tx = 0;
        int            idle_run = 0;
        logic [PW-1:0] prev_data = '0;
        logic          prev_src = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!rstn) begin
                prev_stall = 0; prev_valid = 0; seen_tx = 0; idle_run = 0;
                continue;
            end
            chk("pop_empty", (in0_pop && in0_empty) || (in1_pop && in1_empty), 0);
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_data);
                chk("hold_src", tx_src, prev_src);
            end
            if (tx_valid && !prev_valid && seen_tx) begin
                checks++;
                if (idle_run < IPG) begin
                    errors++;
                    $display("FAIL ipg: got %0d idle cycles required at least %0d", idle_run, IPG);
                end
            end
            if (tx_valid && !tx_ready) begin
                chk("stall_pop", {in1_pop, in0_pop}, 0);
            end else if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx: got packet %0h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_kind_drop", e.drop, 0);
                    chk("tx_data", tx_data, e.data);
                    chk("tx_src", tx_src, e.src);
                    chk("tx_pop", {in1_pop, in0_pop}, e.src ? 2'b10 : 2'b01);
                end
                seen_tx = 1;
            end else if (in0_pop || in1_pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop: got pops %b expected none", {in1_pop, in0_pop});
                end else begin
                    e = exp_q.pop_front();
                    chk("drop_kind", e.drop, 1);
                    chk("drop_pop", {in1_pop, in0_pop}, e.src ? 2'b10 : 2'b01);
                end
            end
            idle_run   = tx_valid ? 0 : idle_run + 1;
            prev_valid = tx_valid;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_src   = tx_src;
        end
    endtask

    task automatic run_main();
        logic [PW-1:0] held;
        bit            got;

        // Single matching packet: one-cycle latency, pop on the accept cycle.
        f0.delete(); f1.delete();
        f0.push_back(mk(MY, 1, 1));
        ready_mode = 0;
        start_phase();
        tick(1'b1);
        chk("lat_first_cycle", tx_valid, 0);
        tick(1'b1);
        chk("lat_valid", tx_valid, 1);
        chk("lat_pop0", in0_pop, 1);
        drain_and_check("single");

        // Both FIFOs loaded: strict alternation starting with FIFO 0.
        f0.delete(); f1.delete();
        for (int i = 0; i < 2; i++) begin
            f0.push_back(mk(MY, 1, 1));
            f1.push_back(mk(MY, 1, 1));
        end
        start_phase();
        drain_and_check("alternate");

        // Sink back-pressure for several cycles.
        f0.delete(); f1.delete();
        f0.push_back(mk(MY, 1, 1));
        ready_mode = 2;
        start_phase();
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(1'b1);
            got = tx_valid;
        end
        chk("stall_reached_valid", got, 1);
        held = tx_data;
        for (int i = 0; i < 5; i++) tick(1'b1);
        chk("stall_data_kept", tx_data, held);
        chk("stall_fifo_kept", f0.size(), 1);
        ready_mode = 0;
        drain_and_check("stall");

        // Foreign-destination head on FIFO 1 must never be taken.
        f0.delete(); f1.delete();
        f0.push_back(mk(MY, 1, 1));
        f0.push_back(mk(MY, 1, 1));
        f1.push_back(mk(PORT_B_ADDR, 1, 1));
        start_phase();
        drain_and_check("foreign");

        // Malformed head on FIFO 0 is discarded and FIFO 1 wins next.
        f0.delete(); f1.delete();
        f0.push_back(mk(MY, 1, 0));
        f0.push_back(mk(MY, 1, 1));
        f1.push_back(mk(MY, 1, 1));
        start_phase();
        drain_and_check("malformed");

        // Reset while a packet is waiting on the sink: it must be offered again exactly once.
        f0.delete(); f1.delete();
        f0.push_back(mk(MY, 1, 1));
        ready_mode = 2;
        start_phase();
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(1'b1);
            got = tx_valid;
        end
        chk("midrst_reached_valid", got, 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_valid_drop", tx_valid, 0);
        chk("midrst_no_pop", {in1_pop, in0_pop}, 0);
        start_phase();
        chk("midrst_fifo_kept", f0.size(), 1);
        ready_mode = 0;
        drain_and_check("midrst");

        // Randomized traffic with random back-pressure.
        for (int r = 0; r < 6; r++) begin
            f0.delete(); f1.delete();
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) f0.push_back(rand_pkt());
            for (int i = 0; i < int'($urandom_range(0, 6)); i++) f1.push_back(rand_pkt());
            ready_mode = (r % 3 == 0) ? 0 : 1;
            start_phase();
            drain_and_check("random");
        end
    endtask

    initial begin
        fork
            run_monitor();
            run_main();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
